shift_mix_columns: RTL and testbench

Round-datapath stage fed directly by the SubBytes stage. It applies AES ShiftRows to the 128-bit state, then MixColumns one column per clock. The result goes to AddRoundKey with the same enable/ready handshake. In the final round, asserting `Last_SMC` skips MixColumns. Processing iteratively keeps one GF(2^8) column mixer instead of four.

---
 rtl/aes_pkg.sv | 23 ++
 rtl/mix_column.sv | 63 ++++++
 rtl/shift_mix_columns.sv | 145 ++++++++++++++
 tb/tb_shift_mix_columns.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// aes_pkg -- shared definitions for the AES round datapath.
//   STATE_W / BYTE_W / NB : state width, byte width, bytes per column (= columns per state)
//   smc_state_t           : shift_mix_columns FSM encoding
//   xtime                 : multiply-by-x in GF(2^8), polynomial x^8+x^4+x^3+x+1
package aes_pkg;

  localparam int STATE_W = 128;
  localparam int BYTE_W  = 8;
  localparam int NB      = 4;
  localparam int COL_W   = NB * BYTE_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_MIX  = 2'd2,
    ST_DONE = 2'd3
  } smc_state_t;

  function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

endpackage

// File: rtl/mix_column.sv
// mix_column -- combinational AES MixColumns on one 32-bit column.
//   col_in  [31:0] : column, row 0 in [31:24]
//   col_out [31:0] : mixed column, same byte order
//   dec            : 1 selects InvMixColumns (port exists only with SMC_INV_EN)
// Optional feature macro: SMC_INV_EN (adds the inverse mixer and dec input).
module mix_column
  import aes_pkg::*;
(
`ifdef SMC_INV_EN
  input  logic             dec,
`endif
  input  logic [COL_W-1:0] col_in,
  output logic [COL_W-1:0] col_out
);

  logic [BYTE_W-1:0] a0, a1, a2, a3;
  logic [BYTE_W-1:0] x0, x1, x2, x3;
  logic [COL_W-1:0]  fwd;

  assign a0 = col_in[31:24];
  assign a1 = col_in[23:16];
  assign a2 = col_in[15:8];
  assign a3 = col_in[7:0];

  assign x0 = xtime(a0);
  assign x1 = xtime(a1);
  assign x2 = xtime(a2);
  assign x3 = xtime(a3);

  // 3*b = xtime(b) ^ b
  assign fwd = {x0 ^ x1 ^ a1 ^ a2 ^ a3,
                a0 ^ x1 ^ x2 ^ a2 ^ a3,
                a0 ^ a1 ^ x2 ^ x3 ^ a3,
                x0 ^ a0 ^ a1 ^ a2 ^ x3};

`ifdef SMC_INV_EN
  // 9/b/d/e multiples built from x, x^2, x^3 terms
  function automatic logic [BYTE_W-1:0] mul9(input logic [BYTE_W-1:0] b);
    return xtime(xtime(xtime(b))) ^ b;
  endfunction
  function automatic logic [BYTE_W-1:0] mulb(input logic [BYTE_W-1:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(b) ^ b;
  endfunction
  function automatic logic [BYTE_W-1:0] muld(input logic [BYTE_W-1:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ b;
  endfunction
  function automatic logic [BYTE_W-1:0] mule(input logic [BYTE_W-1:0] b);
    return xtime(xtime(xtime(b))) ^ xtime(xtime(b)) ^ xtime(b);
  endfunction

  logic [COL_W-1:0] inv;

  assign inv = {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};

  assign col_out = dec ? inv : fwd;
`else
  assign col_out = fwd;
`endif

endmodule

// File: rtl/shift_mix_columns.sv
// shift_mix_columns -- AES ShiftRows followed by iterative MixColumns
// (one column per clock through a single shared column mixer).
//   Clk            : clock, rising edge
//   Rst            : asynchronous active-low reset
//   En_SMC         : start request (ignored while Busy_SMC, except on the
//                    edge that raises Ry_SMC, which accepts back-to-back)
//   Last_SMC       : final round, ShiftRows only; sampled with En_SMC
//   Dec_SMC        : inverse transform; sampled with En_SMC (SMC_INV_EN only)
//   In_SMC  [127:0]: state from SubBytes, byte 0 in [127:120]
//   Ry_SMC         : one-cycle pulse, Out_SMC updated
//   Busy_SMC       : operation in flight
//   Out_SMC [127:0]: result, held until the next result
// Optional feature macro: SMC_INV_EN (inverse ShiftRows/MixColumns, Dec_SMC port).
module shift_mix_columns
  import aes_pkg::*;
#(
  parameter int COLS = 4
) (
  input  logic               Clk,
  input  logic               Rst,
  input  logic               En_SMC,
  input  logic               Last_SMC,
`ifdef SMC_INV_EN
  input  logic               Dec_SMC,
`endif
  input  logic [STATE_W-1:0] In_SMC,
  output logic               Ry_SMC,
  output logic               Busy_SMC,
  output logic [STATE_W-1:0] Out_SMC
);

  localparam int            CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  smc_state_t         state, state_nxt;
  logic [CW-1:0]      col;
  logic [STATE_W-1:0] st;
  logic               last_q;
  logic               load, mix_en, done;
  logic [COL_W-1:0]   col_word, col_mixed;

`ifdef SMC_INV_EN
  logic dec_q;

  function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s,
                                                    input logic inv);
`else
  function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
`endif
    logic [STATE_W-1:0] o;
    int src;
    o = '0;
    for (int c = 0; c < NB; c++) begin
      for (int r = 0; r < NB; r++) begin
`ifdef SMC_INV_EN
        src = inv ? (c - r + NB) % NB : (c + r) % NB;
`else
        src = (c + r) % NB;
`endif
        o[STATE_W-1-BYTE_W*(NB*c+r) -: BYTE_W] = s[STATE_W-1-BYTE_W*(NB*src+r) -: BYTE_W];
      end
    end
    return o;
  endfunction

  assign Busy_SMC = (state != ST_IDLE);

  // Column under mix this cycle; column 0 occupies the top 32 bits.
  assign col_word = st[STATE_W-1-COL_W*int'(col) -: COL_W];

  mix_column u_mix (
`ifdef SMC_INV_EN
    .dec     (dec_q),
`endif
    .col_in  (col_word),
    .col_out (col_mixed)
  );

  // The LOAD slot after acceptance holds the freshly shifted state for one
  // cycle before mixing starts; it fixes the cadence at 6 cycles per block
  // (2 on the final round) with back-to-back acceptance on the DONE edge.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    mix_en    = 1'b0;
    done      = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (En_SMC) begin
          load      = 1'b1;
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_nxt = last_q ? ST_DONE : ST_MIX;
      end
      ST_MIX: begin
        mix_en = 1'b1;
        if (col == COL_LAST) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done = 1'b1;
        if (En_SMC) begin
          load      = 1'b1;
          state_nxt = ST_LOAD;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state   <= ST_IDLE;
      col     <= '0;
      st      <= '0;
      last_q  <= 1'b0;
`ifdef SMC_INV_EN
      dec_q   <= 1'b0;
`endif
      Out_SMC <= '0;
      Ry_SMC  <= 1'b0;
    end else begin
      state  <= state_nxt;
      Ry_SMC <= done;
      if (done) Out_SMC <= st;
      if (load) begin
        last_q <= Last_SMC;
        col    <= '0;
`ifdef SMC_INV_EN
        dec_q  <= Dec_SMC;
        st     <= shift_rows(In_SMC, Dec_SMC);
`else
        st     <= shift_rows(In_SMC);
`endif
      end else if (mix_en) begin
        st[STATE_W-1-COL_W*int'(col) -: COL_W] <= col_mixed;
        col <= (col == COL_LAST) ? '0 : col + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_shift_mix_columns.sv
// tb_shift_mix_columns -- directed self-checking bench for shift_mix_columns.
// Inverse-path vectors are included when SMC_INV_EN is defined.
module tb_shift_mix_columns;

  localparam logic [127:0] FIPS_IN   = 128'hd42711aee0bf98f1b8b45de51e415230;
  localparam logic [127:0] FIPS_OUT  = 128'h046681e5e0cb199a48f8d37a2806264c;
  localparam logic [127:0] FIPS_LAST = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
  localparam logic [127:0] SAME_IN   = {4{32'hdb135345}};
  localparam logic [127:0] SAME_OUT  = {4{32'h8e4da1bc}};

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         last = 1'b0;
`ifdef SMC_INV_EN
  logic         dec = 1'b0;
`endif
  logic [127:0] din = '0;
  logic         ry, busy;
  logic [127:0] dout;

  int tests = 0;
  int fails = 0;

  shift_mix_columns #(.COLS(4)) dut (
    .Clk      (clk),
    .Rst      (rst_n),
    .En_SMC   (en),
    .Last_SMC (last),
`ifdef SMC_INV_EN
    .Dec_SMC  (dec),
`endif
    .In_SMC   (din),
    .Ry_SMC   (ry),
    .Busy_SMC (busy),
    .Out_SMC  (dout)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Start one block and follow it to Ry_SMC. poke_at >= 0 pulses En_SMC
  // (with junk data) before that edge count, which must be ignored.
  task automatic run_op(input string tag, input logic [127:0] d_in, input logic l,
                        input int exp_lat, input logic [127:0] exp_out, input int poke_at);
    int n;
    int bcnt;
    @(negedge clk);
    din  = d_in;
    last = l;
    en   = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
    din = ~d_in;
    n    = 0;
    bcnt = 0;
    while (ry !== 1'b1 && n < 20) begin
      if (busy === 1'b1) bcnt++;
      if (n == poke_at) begin
        en   = 1'b1;
        din  = 128'h0123456789abcdef0123456789abcdef;
        last = 1'b1;
      end
      @(posedge clk);
      #1;
      en = 1'b0;
      n++;
    end
    check({tag, "_latency"}, 128'(n), 128'(exp_lat));
    check({tag, "_out"}, dout, exp_out);
    check({tag, "_busy_cycles"}, 128'(bcnt), 128'(exp_lat));
    check({tag, "_busy_low_at_ry"}, 128'(busy), 128'(0));
    @(posedge clk);
    #1;
    check({tag, "_ry_one_cycle"}, 128'(ry), 128'(0));
    check({tag, "_out_held"}, dout, exp_out);
  endtask

  initial begin
    int ry_seen;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_ry", 128'(ry), 128'(0));
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_out", dout, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Main function
    run_op("fips_round1", FIPS_IN, 1'b0, 6, FIPS_OUT, -1);
    run_op("same_cols", SAME_IN, 1'b0, 6, SAME_OUT, -1);
    run_op("last_round", FIPS_IN, 1'b1, 2, FIPS_LAST, -1);

    // En_SMC during MIX is ignored
    run_op("en_during_mix", FIPS_IN, 1'b0, 6, FIPS_OUT, 2);

    // Back-to-back: second start on the edge that raises Ry_SMC
    @(negedge clk);
    din  = FIPS_IN;
    last = 1'b0;
    en   = 1'b1;
    @(posedge clk);
    #1;
    en  = 1'b0;
    din = '0;
    repeat (5) @(posedge clk);
    #1;
    check("b2b_first_not_yet", 128'(ry), 128'(0));
    din = SAME_IN;
    en  = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    check("b2b_first_ry", 128'(ry), 128'(1));
    check("b2b_first_out", dout, FIPS_OUT);
    check("b2b_second_busy", 128'(busy), 128'(1));
    repeat (5) @(posedge clk);
    #1;
    check("b2b_second_not_yet", 128'(ry), 128'(0));
    @(posedge clk);
    #1;
    check("b2b_second_ry", 128'(ry), 128'(1));
    check("b2b_second_out", dout, SAME_OUT);
    @(posedge clk);
    #1;
    check("b2b_ry_drop", 128'(ry), 128'(0));

    // Reset while mixing column 2
    @(negedge clk);
    din = FIPS_IN;
    last = 1'b0;
    en = 1'b1;
    @(posedge clk);
    #1;
    en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("midmix_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    check("midmix_rst_ry", 128'(ry), 128'(0));
    check("midmix_rst_busy", 128'(busy), 128'(0));
    check("midmix_rst_out", dout, 128'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ry_seen = 0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (ry === 1'b1) ry_seen++;
    end
    check("midmix_no_ry", 128'(ry_seen), 128'(0));
    check("midmix_out_still_zero", dout, 128'h0);
    run_op("after_reset", FIPS_IN, 1'b0, 6, FIPS_OUT, -1);

`ifdef SMC_INV_EN
    dec = 1'b1;
    run_op("inv_same_cols", SAME_OUT, 1'b0, 6, SAME_IN, -1);
    run_op("inv_last_round", FIPS_LAST, 1'b1, 2, FIPS_IN, -1);
    dec = 1'b0;
    run_op("fwd_after_inv", FIPS_IN, 1'b0, 6, FIPS_OUT, -1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
